stdp_learn: RTL and testbench

STDP_LEARN -- requirements
Module: stdp_learn

---
 rtl/stdp_pkg.sv | 30 +++
 rtl/stdp_timer.sv | 23 ++
 rtl/stdp_learn.sv | 198 +++++++++++++++++++
 tb/tb_stdp_learn.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// stdp_pkg: shared types, parameter defaults and weight arithmetic for the
// STDP learning block.
package stdp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int N_PRE_DEF       = 8;
    localparam int TW_DEF          = 8;
    localparam int WW_DEF          = 8;
    localparam int WINDOW_DEF      = 16;
    localparam int A_PLUS_DEF      = 16;
    localparam int A_MINUS_DEF     = 8;
    localparam int DECAY_SHIFT_DEF = 2;
    localparam int W_INIT_DEF      = 128;

    // Signed add of a weight and a signed delta, clamped to [0, max_val].
    function automatic logic [31:0] sat_add(input logic signed [31:0] a,
                                            input logic signed [31:0] b,
                                            input logic [31:0]        max_val);
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        if (s < 0) return '0;
        if (s > $signed({1'b0, max_val})) return max_val;
        return s[31:0];
    endfunction

endpackage

// File: rtl/stdp_timer.sv
// stdp_timer: cycles-since-last-spike counter; clears on a spike and
// saturates at all-ones instead of wrapping.
module stdp_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spike,
    output logic [TW-1:0] value
);

    // Load zero on spike, otherwise count up until saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '1;
        end else if (spike) begin
            value <= '0;
        end else if (value != '1) begin
            value <= value + TW'(1);
        end
    end

endmodule

// File: rtl/stdp_learn.sv
// stdp_learn: pair-based STDP weight learning for N_PRE synapses feeding one
// post-synaptic neuron. Spike events latch pending LTP/LTD updates; a scan
// engine applies one channel per cycle to the weight table.
// Optional: define STDP_UPD_MON_EN to add upd_valid/upd_idx/upd_weight.
module stdp_learn
    import stdp_pkg::*;
#(
    parameter int N_PRE       = N_PRE_DEF,
    parameter int TW          = TW_DEF,
    parameter int WW          = WW_DEF,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int A_PLUS      = A_PLUS_DEF,
    parameter int A_MINUS     = A_MINUS_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
    parameter int W_INIT      = W_INIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_PRE-1:0]         pre_spike,
    input  logic                     post_spike,
    input  logic                     wr_en,
    input  logic [$clog2(N_PRE)-1:0] wr_idx,
    input  logic [WW-1:0]            wr_data,
    input  logic [$clog2(N_PRE)-1:0] rd_idx,
    output logic [WW-1:0]            rd_weight,
    output logic                     busy
`ifdef STDP_UPD_MON_EN
    ,
    output logic                     upd_valid,
    output logic [$clog2(N_PRE)-1:0] upd_idx,
    output logic [WW-1:0]            upd_weight
`endif
);

    localparam int          IW   = $clog2(N_PRE);
    localparam int          AW   = WW + 2;
    localparam logic [31:0] WMAX = 32'((64'd1 << WW) - 64'd1);

    logic [TW-1:0]        pre_t [N_PRE];
    logic [TW-1:0]        post_t;

    logic [N_PRE-1:0]     ltp_pend;
    logic [N_PRE-1:0]     ltd_pend;
    logic [N_PRE-1:0]     ltp_set;
    logic [N_PRE-1:0]     ltd_set;
    logic [N_PRE-1:0]     clr;
    logic [TW-1:0]        ltp_dt     [N_PRE];
    logic [TW-1:0]        ltd_dt     [N_PRE];
    logic [TW-1:0]        ltp_dt_new [N_PRE];

    logic [WW-1:0]        weight [N_PRE];

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 pend_left;

    logic [AW-1:0]        ltp_amp;
    logic [AW-1:0]        ltd_amp;
    logic signed [AW-1:0] delta;
    logic [WW-1:0]        new_w;
    logic                 eng_apply;

    for (genvar g = 0; g < N_PRE; g++) begin : g_pre_timer
        stdp_timer #(.TW(TW)) u_timer (
            .clk   (clk),
            .rst   (rst),
            .spike (pre_spike[g]),
            .value (pre_t[g])
        );
    end

    stdp_timer #(.TW(TW)) u_post_timer (
        .clk   (clk),
        .rst   (rst),
        .spike (post_spike),
        .value (post_t)
    );

    // Spike pairing: a coincident pre/post pair is LTP with dt=0 and never LTD.
    always_comb begin
        ltp_set = '0;
        ltd_set = '0;
        for (int unsigned i = 0; i < N_PRE; i++) begin
            ltp_dt_new[i] = pre_spike[i] ? '0 : pre_t[i];
            if (en && post_spike && (pre_spike[i] || (32'(pre_t[i]) < WINDOW)))
                ltp_set[i] = 1'b1;
            if (en && pre_spike[i] && !post_spike && (32'(post_t) < WINDOW))
                ltd_set[i] = 1'b1;
        end
    end

    // Engine clear mask and whether anything is still pending after this cycle.
    always_comb begin
        clr       = (state == SCAN) ? (N_PRE'(1) << idx) : '0;
        pend_left = |(ltp_set | ltd_set | ((ltp_pend | ltd_pend) & ~clr));
    end

    // Net decayed delta for the scanned channel and its saturated new weight.
    always_comb begin
        ltp_amp = '0;
        ltd_amp = '0;
        if (ltp_pend[idx]) ltp_amp = AW'(A_PLUS) >> (ltp_dt[idx] >> DECAY_SHIFT);
        if (ltd_pend[idx]) ltd_amp = AW'(A_MINUS) >> (ltd_dt[idx] >> DECAY_SHIFT);
        delta     = $signed(ltp_amp) - $signed(ltd_amp);
        new_w     = WW'(sat_add(32'(weight[idx]), 32'(delta), WMAX));
        eng_apply = (state == SCAN) && (ltp_pend[idx] || ltd_pend[idx])
                    && !(wr_en && (wr_idx == idx));
    end

    // Pending bits: a new event sets (latest dt wins) and beats the engine clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ltp_pend <= '0;
            ltd_pend <= '0;
            for (int unsigned i = 0; i < N_PRE; i++) begin
                ltp_dt[i] <= '0;
                ltd_dt[i] <= '0;
            end
        end else begin
            ltp_pend <= ltp_set | (ltp_pend & ~clr);
            ltd_pend <= ltd_set | (ltd_pend & ~clr);
            for (int unsigned i = 0; i < N_PRE; i++) begin
                if (ltp_set[i]) ltp_dt[i] <= ltp_dt_new[i];
                if (ltd_set[i]) ltd_dt[i] <= post_t;
            end
        end
    end

    // Weight table: host write overrides an engine update to the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_PRE; i++) weight[i] <= WW'(W_INIT);
        end else begin
            if (eng_apply) weight[idx] <= new_w;
            if (wr_en && (32'(wr_idx) < N_PRE)) weight[wr_idx] <= wr_data;
        end
    end

    // Scan FSM: walk all channels, wrapping while anything is still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(ltp_pend | ltd_pend)) begin
                        state <= SCAN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == IW'(N_PRE - 1)) begin
                        idx <= '0;
                        if (!pend_left) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational weight read; out-of-range selects read as zero.
    always_comb begin
        rd_weight = '0;
        if (32'(rd_idx) < N_PRE) rd_weight = weight[rd_idx];
    end

`ifdef STDP_UPD_MON_EN
    // One-cycle pulse per applied engine update carrying the new weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_weight <= '0;
        end else begin
            upd_valid <= eng_apply;
            if (eng_apply) begin
                upd_idx    <= idx;
                upd_weight <= new_w;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stdp_learn.sv
// tb_stdp_learn: directed and randomized checks of stdp_learn against a
// transaction-level STDP model (spike times -> dt -> decayed delta).
module tb_stdp_learn;

    localparam int N      = 8;
    localparam int WIN    = 16;
    localparam int AP     = 16;
    localparam int AM     = 8;
    localparam int DSH    = 2;
    localparam int WINIT  = 128;
    localparam int TMAX   = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pre_spike;
    logic       post_spike;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic [2:0] rd_idx;
    logic [7:0] rd_weight;
    logic       busy;
`ifdef STDP_UPD_MON_EN
    logic       upd_valid;
    logic [2:0] upd_idx;
    logic [7:0] upd_weight;
    int         mon_cnt = 0;
`endif

    int total = 0;
    int bad   = 0;

    longint cyc = 0;
    longint last_pre [N];
    longint last_post;
    int     mw       [N];
    bit     m_ltp    [N];
    bit     m_ltd    [N];
    int     m_ltp_dt [N];
    int     m_ltd_dt [N];

    stdp_learn #(
        .N_PRE(8), .TW(8), .WW(8), .WINDOW(16), .A_PLUS(16), .A_MINUS(8),
        .DECAY_SHIFT(2), .W_INIT(128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx),
        .rd_weight  (rd_weight),
        .busy       (busy)
`ifdef STDP_UPD_MON_EN
        ,
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_weight (upd_weight)
`endif
    );

    always #10 clk = ~clk;

`ifdef STDP_UPD_MON_EN
    always @(negedge clk) if (upd_valid === 1'b1) mon_cnt++;
`endif

    // ---------------- model / stimulus helpers ----------------
    function automatic int tval(input longint last, input longint e);
        longint d;
        d = e - last - 1;
        return (d > TMAX) ? TMAX : int'(d);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick;
    endtask

    task automatic model_reset;
        for (int i = 0; i < N; i++) begin
            mw[i] = WINIT; last_pre[i] = -1000;
            m_ltp[i] = 0; m_ltd[i] = 0; m_ltp_dt[i] = 0; m_ltd_dt[i] = 0;
        end
        last_post = -1000;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        model_reset;
    endtask

    // Drive one spike edge and record which updates the STDP rule creates.
    task automatic fire(input logic [7:0] m, input logic p);
        longint e;
        int     t;
        e = cyc + 1;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (p) begin
                    t = m[i] ? 0 : tval(last_pre[i], e);
                    if (t < WIN) begin m_ltp[i] = 1; m_ltp_dt[i] = t; end
                end else if (m[i]) begin
                    t = tval(last_post, e);
                    if (t < WIN) begin m_ltd[i] = 1; m_ltd_dt[i] = t; end
                end
            end
        end
        for (int i = 0; i < N; i++) if (m[i]) last_pre[i] = e;
        if (p) last_post = e;
        pre_spike  = m;
        post_spike = p;
        tick;
        pre_spike  = '0;
        post_spike = 1'b0;
    endtask

    task automatic model_apply;
        int d;
        for (int i = 0; i < N; i++) begin
            if (m_ltp[i] || m_ltd[i]) begin
                d = 0;
                if (m_ltp[i]) d += AP >> (m_ltp_dt[i] >> DSH);
                if (m_ltd[i]) d -= AM >> (m_ltd_dt[i] >> DSH);
                mw[i] = mw[i] + d;
                if (mw[i] < 0)   mw[i] = 0;
                if (mw[i] > 255) mw[i] = 255;
            end
            m_ltp[i] = 0;
            m_ltd[i] = 0;
        end
    endtask

    task automatic wr(input logic [2:0] i, input logic [7:0] d);
        wr_en = 1'b1; wr_idx = i; wr_data = d;
        tick;
        wr_en = 1'b0;
        mw[i] = d;
    endtask

    // Wait for the engine to finish; ok=0 if it never goes idle.
    task automatic drain(output bit ok);
        int n;
        n = 0;
        tick;
        tick;
        while (busy && n < 40) begin tick; n++; end
        ok = !busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset;
        total++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); bad++; end
`ifdef STDP_UPD_MON_EN
        total++;
        if (upd_valid !== 1'b0) begin $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); bad++; end
`endif
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'(WINIT)) begin
                $display("FAIL reset_weight ch%0d got=%0d exp=%0d", i, rd_weight, WINIT); bad++;
            end
        end
    endtask

    task automatic test_ltp;
        bit ok;
        do_reset;
        fire(8'h08, 1'b0);
        idle(3);
        fire(8'h00, 1'b1);
        drain(ok);
        model_apply;
        total++;
        if (!ok) begin $display("FAIL ltp_drain busy still high"); bad++; end
        rd_idx = 3'd3; #1;
        total++;
        if (rd_weight !== 8'd144) begin $display("FAIL ltp_w3 got=%0d exp=144", rd_weight); bad++; end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'(mw[i])) begin
                $display("FAIL ltp_model ch%0d got=%0d exp=%0d", i, rd_weight, mw[i]); bad++;
            end
        end
    endtask

    task automatic test_ltd;
        bit ok;
        do_reset;
        fire(8'h00, 1'b1);
        idle(9);
        fire(8'h20, 1'b0);
        drain(ok);
        model_apply;
        total++;
        if (!ok) begin $display("FAIL ltd_drain busy still high"); bad++; end
        rd_idx = 3'd5; #1;
        total++;
        if (rd_weight !== 8'd126) begin $display("FAIL ltd_w5 got=%0d exp=126", rd_weight); bad++; end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'(mw[i])) begin
                $display("FAIL ltd_model ch%0d got=%0d exp=%0d", i, rd_weight, mw[i]); bad++;
            end
        end
    endtask

    task automatic test_saturation;
        bit ok;
        do_reset;
        wr(3'd0, 8'd250);
        fire(8'h01, 1'b1);
        drain(ok);
        model_apply;
        rd_idx = 3'd0; #1;
        total++;
        if (rd_weight !== 8'd255) begin $display("FAIL sat_high_w0 got=%0d exp=255", rd_weight); bad++; end
        wr(3'd1, 8'd3);
        fire(8'h00, 1'b1);
        fire(8'h02, 1'b0);
        drain(ok);
        model_apply;
        total++;
        if (!ok) begin $display("FAIL sat_drain busy still high"); bad++; end
        rd_idx = 3'd1; #1;
        total++;
        if (rd_weight !== 8'd0) begin $display("FAIL sat_low_w1 got=%0d exp=0", rd_weight); bad++; end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'(mw[i])) begin
                $display("FAIL sat_model ch%0d got=%0d exp=%0d", i, rd_weight, mw[i]); bad++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        do_reset;
        fire(8'hFF, 1'b0);
        idle(1);
        fire(8'h00, 1'b1);
        cnt = 0;
        repeat (12) begin tick; if (busy === 1'b1) cnt++; end
        model_apply;
        total++;
        if (cnt != 8) begin $display("FAIL b2b_busy_cycles got=%0d exp=8", cnt); bad++; end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'd144 || rd_weight !== 8'(mw[i])) begin
                $display("FAIL b2b_weight ch%0d got=%0d exp=144 model=%0d", i, rd_weight, mw[i]); bad++;
            end
        end
    endtask

    task automatic test_abort;
        do_reset;
        fire(8'hFF, 1'b0);
        idle(1);
        fire(8'h00, 1'b1);
        idle(4);
        total++;
        if (busy !== 1'b1) begin $display("FAIL abort_pre_busy got=%b exp=1", busy); bad++; end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin $display("FAIL abort_busy got=%b exp=0", busy); bad++; end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'(WINIT)) begin
                $display("FAIL abort_weight ch%0d got=%0d exp=%0d", i, rd_weight, WINIT); bad++;
            end
        end
        tick;
        rst = 1'b0;
        model_reset;
        idle(3);
        total++;
        if (busy !== 1'b0) begin $display("FAIL abort_after_busy got=%b exp=0", busy); bad++; end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i); #1;
            total++;
            if (rd_weight !== 8'(WINIT)) begin
                $display("FAIL abort_after_weight ch%0d got=%0d exp=%0d", i, rd_weight, WINIT); bad++;
            end
        end
    endtask

    task automatic test_window;
        int cnt;
        do_reset;
        fire(8'h04, 1'b0);
        idle(19);
        fire(8'h00, 1'b1);
        cnt = 0;
        repeat (4) begin tick; if (busy !== 1'b0) cnt++; end
        total++;
        if (cnt != 0) begin $display("FAIL window_busy got=%0d exp=0", cnt); bad++; end
        rd_idx = 3'd2; #1;
        total++;
        if (rd_weight !== 8'd128) begin $display("FAIL window_w2 got=%0d exp=128", rd_weight); bad++; end
        en = 1'b0;
        fire(8'h04, 1'b0);
        idle(3);
        fire(8'h00, 1'b1);
        cnt = 0;
        repeat (4) begin tick; if (busy !== 1'b0) cnt++; end
        total++;
        if (cnt != 0) begin $display("FAIL en0_busy got=%0d exp=0", cnt); bad++; end
        rd_idx = 3'd2; #1;
        total++;
        if (rd_weight !== 8'd128) begin $display("FAIL en0_w2 got=%0d exp=128", rd_weight); bad++; end
        en = 1'b1;
        fire(8'h00, 1'b1);
        idle(12);
        model_apply;
        rd_idx = 3'd2; #1;
        total++;
        if (rd_weight !== 8'd132 || rd_weight !== 8'(mw[2])) begin
            $display("FAIL en0_timer_w2 got=%0d exp=132 model=%0d", rd_weight, mw[2]); bad++;
        end
    endtask

    task automatic test_host_collision;
        bit ok;
        do_reset;
        fire(8'h80, 1'b1);
        idle(8);
        rd_idx = 3'd7; #1;
        total++;
        if (rd_weight !== 8'd128) begin $display("FAIL coll_before got=%0d exp=128", rd_weight); bad++; end
        m_ltp[7] = 0;
        wr(3'd7, 8'd50);
        drain(ok);
        model_apply;
        total++;
        if (!ok) begin $display("FAIL coll_drain busy still high"); bad++; end
        rd_idx = 3'd7; #1;
        total++;
        if (rd_weight !== 8'd50) begin $display("FAIL coll_w7 got=%0d exp=50", rd_weight); bad++; end
    endtask

    task automatic test_random;
        bit ok;
        int exp_n;
        int m0;
        do_reset;
        for (int it = 0; it < 40; it++) begin
            for (int ph = 0; ph < 2; ph++) begin
                en = ($urandom_range(0, 4) != 0);
                if (ph == 1) fire(8'($urandom()), ($urandom_range(0, 3) != 0));
                else         fire(8'($urandom()), ($urandom_range(0, 1) == 1));
                exp_n = 0;
                for (int i = 0; i < N; i++) if (m_ltp[i] || m_ltd[i]) exp_n++;
`ifdef STDP_UPD_MON_EN
                m0 = mon_cnt;
`else
                m0 = exp_n;
`endif
                drain(ok);
                model_apply;
                total++;
                if (!ok) begin $display("FAIL rand_drain it%0d busy still high", it); bad++; end
                for (int i = 0; i < N; i++) begin
                    rd_idx = 3'(i); #1;
                    total++;
                    if (rd_weight !== 8'(mw[i])) begin
                        $display("FAIL rand_weight it%0d ph%0d ch%0d got=%0d exp=%0d", it, ph, i, rd_weight, mw[i]);
                        bad++;
                    end
                end
`ifdef STDP_UPD_MON_EN
                tick;
                total++;
                if (mon_cnt - m0 != exp_n) begin
                    $display("FAIL rand_upd_pulses it%0d got=%0d exp=%0d", it, mon_cnt - m0, exp_n); bad++;
                end
`endif
                if (ph == 0) idle($urandom_range(0, 12));
            end
            if ($urandom_range(0, 3) == 0) wr(3'($urandom_range(0, 7)), 8'($urandom()));
        end
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; pre_spike = '0; post_spike = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        model_reset;
        test_reset;
        test_ltp;
        test_ltd;
        test_saturation;
        test_back_to_back;
        test_abort;
        test_window;
        test_host_collision;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
